// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM port arbiter.
// Used by rr_arbiter and ram_port_arbiter (optional RAM_ARB_INIT_EN build).
package ram_arb_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_INIT = 1'b1
    } arb_state_e;

    localparam int MAX_REQ = 8;

    // Index width for n requesters, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Returns {found, index} of the first set bit scanning upward from start+1, wrapping at n.
    function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [2:0] start,
                                           input int n);
        logic [3:0] res;
        int idx;
        res = '0;
        for (int i = n; i >= 1; i--) begin
            idx = (int'(start) + i) % n;
            if (req[idx]) res = {1'b1, 3'(idx)};
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick over NUM_REQ request lines with a registered priority pointer.
// Part of ram_port_arbiter (optional RAM_ARB_INIT_EN build).
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IW      = idx_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               valid_o,
    output logic [IW-1:0]      idx_o
);

    logic [IW-1:0]      ptr_q;
    logic [MAX_REQ-1:0] req_ext;
    logic [3:0]         pick;

    assign req_ext = MAX_REQ'(req_i);
    assign pick    = rr_pick(req_ext, 3'(ptr_q), NUM_REQ);
    assign valid_o = pick[3] & en_i;
    assign idx_o   = IW'(pick[2:0]);

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
        assign gnt_o[gi] = valid_o && (pick[2:0] == 3'(gi));
    end

    // Reset value makes requester 0 the first in line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= IW'(NUM_REQ - 1);
        end else if (valid_o) begin
            ptr_q <= idx_o;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin sharing of one RAM port between NUM_REQ requesters with registered commands.
// Define RAM_ARB_INIT_EN to zero-fill the RAM after reset before accepting requests.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 5,
    parameter  int NUM_REQ    = 4,
    localparam int IW         = idx_width(NUM_REQ)
) (
    input  logic                           iClk,
    input  logic                           iRst_n,
    input  logic [NUM_REQ-1:0]             iReq,
    input  logic [NUM_REQ-1:0]             iWe,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  iAddr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  iData,
    output logic [NUM_REQ-1:0]             oGnt,
    output logic [NUM_REQ-1:0]             oRdValid,
    output logic [DATA_WIDTH-1:0]          oRdData,
    output logic                           oReady,
    output logic                           oRamEn,
    output logic                           oRamWe,
    output logic [ADDR_WIDTH-1:0]          oRamAddr,
    output logic [DATA_WIDTH-1:0]          oRamData,
    input  logic [DATA_WIDTH-1:0]          iRamData
);

    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [NUM_REQ-1:0]    rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  ready_q, ready_d;
    logic                  ram_en_q, ram_en_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic                  run;
    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    pick_gnt;
    logic                  pick_valid;
    logic [IW-1:0]         pick_idx;
    logic [NUM_REQ-1:0]    rd_gnt;

`ifdef RAM_ARB_INIT_EN
    arb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q;
    assign run = (state_q == ST_RUN);
`else
    assign run = 1'b1;
`endif

    // The requester served in this cycle is masked so it cannot win twice in a row.
    assign eligible = iReq & ~gnt_q;
    assign rd_gnt   = gnt_q & {NUM_REQ{~ram_we_q}};

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk     (iClk),
        .rst_n   (iRst_n),
        .en_i    (run),
        .req_i   (eligible),
        .gnt_o   (pick_gnt),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        gnt_d    = pick_gnt;
        ram_en_d = pick_valid;
        ram_we_d = pick_valid & iWe[pick_idx];
        addr_d   = pick_valid ? iAddr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH] : addr_q;
        data_d   = pick_valid ? iData[pick_idx*DATA_WIDTH +: DATA_WIDTH] : data_q;
        ready_d  = 1'b1;
`ifdef RAM_ARB_INIT_EN
        state_d  = state_q;
        ready_d  = (state_q == ST_RUN);
        if (state_q == ST_INIT) begin
            gnt_d    = '0;
            ram_en_d = 1'b1;
            ram_we_d = 1'b1;
            addr_d   = cnt_q;
            data_d   = '0;
            if (&cnt_q) state_d = ST_RUN;
        end
`endif
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            gnt_q      <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            ready_q    <= 1'b0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
`ifdef RAM_ARB_INIT_EN
            state_q    <= ST_INIT;
            cnt_q      <= '0;
`endif
        end else begin
            gnt_q      <= gnt_d;
            rd_valid_q <= rd_gnt;
            if (|rd_gnt) rd_data_q <= iRamData;
            ready_q    <= ready_d;
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
`ifdef RAM_ARB_INIT_EN
            state_q    <= state_d;
            if (state_q == ST_INIT) cnt_q <= cnt_q + ADDR_WIDTH'(1);
`endif
        end
    end

    assign oGnt     = gnt_q;
    assign oRdValid = rd_valid_q;
    assign oRdData  = rd_data_q;
    assign oReady   = ready_q;
    assign oRamEn   = ram_en_q;
    assign oRamWe   = ram_we_q;
    assign oRamAddr = addr_q;
    assign oRamData = data_q;

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one port (A or B) of the processor's dual-port RAM between NUM_REQ requesters, for example fetch, load/store and debug.
- Round-robin arbitration with a request/grant handshake.
- Drives the RAM port's enable, write-enable, address and data.
- Returns read data to the winning requester with a per-requester valid pulse.

Parameters:
DATA_WIDTH, 32, RAM word width
ADDR_WIDTH, 5, RAM address width
NUM_REQ, 4, number of requesters (2..8)

Ports:
iClk  in  1  single clock; also drives the RAM port clock
iRst_n  in  1  reset, synchronous, active-low
iReq  in  NUM_REQ  per-requester request; held with its command until granted
iWe  in  NUM_REQ  per-requester write flag (1 = write, 0 = read)
iAddr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i in slice [i*ADDR_WIDTH +: ADDR_WIDTH]
iData  in  NUM_REQ*DATA_WIDTH  packed write data, same packing
oGnt  out  NUM_REQ  one-hot grant; the access is issued in the cycle oGnt is high
oRdValid  out  NUM_REQ  one-cycle pulse: oRdData belongs to requester i
oRdData  out  DATA_WIDTH  registered read data
oReady  out  1  arbiter accepting requests
oRamEn  out  1  to RAM iEn
oRamWe  out  1  to RAM iWe
oRamAddr  out  ADDR_WIDTH  to RAM iAddr
oRamData  out  DATA_WIDTH  to RAM iData
iRamData  in  DATA_WIDTH  from RAM oData

Behaviour:
- Reset (iRst_n=0 at a posedge): all outputs are 0 from the next cycle. Round-robin pointer = NUM_REQ-1, so requester 0 has highest priority first. State = RUN, or INIT when the optional feature is enabled.
- Any access in flight at reset is dropped; no oRdValid is emitted for it.
- Arbitration, posedge k:
  - Eligible set = iReq & ~oGnt. The currently granted requester is consumed at this edge and masked.
  - Winner = first eligible index scanning from pointer+1 upward, wrapping modulo NUM_REQ.
  - Registered outputs: oGnt = onehot(winner), oRamEn = 1, oRamWe = iWe[winner], oRamAddr and oRamData from the winner's slices. Pointer <= winner.
  - No eligible requester: oGnt = 0, oRamEn = 0, oRamWe = 0. Addr/data hold their previous value. Pointer is unchanged.
- RAM timing: the RAM samples on the negedge inside cycle k..k+1.
- Read return, posedge k+1 (read grant only): oRdData <= iRamData and oRdValid[winner] = 1 for exactly one cycle. Read latency = 1 cycle after the grant cycle. oRdData holds until the next read.
- Write grant: no oRdValid. The RAM is read-first, so the old data it returns is discarded.
- Requester handshake:
  - Command must be stable while iReq=1 and oGnt[i]=0.
  - It may change or drop at the edge ending the oGnt[i] cycle.
  - Dropping iReq before grant withdraws the request, which is legal.
- Throughput:
  - One access per cycle when two or more requesters are active.
  - A single requester gets at most one access per 2 cycles (mask rule).
- Read-after-write to the same address in consecutive cycles returns the new data, because the write lands at negedge k and the read at negedge k+1.
- oGnt is always one-hot or zero. Never grant while oReady=0.
- NUM_REQ=1: the pointer is a constant and the mask rule still applies.

Optional Feature:
RAM_ARB_INIT_EN
- Enabled: after reset the FSM enters INIT.
  - Issues writes of 0 to addresses 0..2**ADDR_WIDTH-1, one per cycle: oRamEn=1, oRamWe=1, oRamAddr = counter.
  - oReady=0 and oGnt=0 throughout.
  - After the last address it enters RUN with oReady=1; this takes 2**ADDR_WIDTH cycles.
  - Requests held during INIT are served after it finishes.
- Disabled: no INIT state and no counter; oReady=1 from the first cycle after reset.

Decomposition:
- Shared package/include ram_arb_pkg:
  - state encodings ST_RUN and ST_INIT
  - a clog2-based index-width constant function
  - a rotate-priority function (pick first set bit from a start index)
- One natural sub-module, rr_arbiter: combinational round-robin pick plus the registered pointer, parameterised by NUM_REQ.
- ram_port_arbiter contains the FSM, command mux, output registers and read-return logic.

Test Plan:
- Reset then single read: iReq=4'b0001, iAddr0=3, RAM[3]=0xDEADBEEF -> oGnt=0001 one cycle later; next cycle oRdValid=0001, oRdData=0xDEADBEEF.
- All four requesting reads continuously -> grant order 0,1,2,3,0,…; one grant per cycle; each oRdValid one cycle after its grant.
- Requester 2 alone holds iReq for 4 transactions -> grants on alternate cycles only; oGnt never high on two consecutive cycles.
- Requester 1 writes 0x12345678 to addr 7; requester 0 then reads addr 7 in the next grant -> oRdData=0x12345678; the write produces no oRdValid.
- iRst_n=0 during the cycle a read grant is high -> no oRdValid afterwards; all outputs 0; after release, requester 0 wins first.
- With RAM_ARB_INIT_EN, ADDR_WIDTH=5 -> oReady low for 32 cycles, with writes of 0 to addrs 0..31; a pending iReq is granted on the first cycle after oReady rises.
